sparc_exu_ccr_wrsched: RTL

CCR write-port scheduler for the EXU condition-code registers. It merges three CCR writers into the single registered write port that feeds the per-thread CCR storage:
- the W-stage pipeline write (ALU setcc / WRCCR);
- the TLU restore write (DONE/RETRY);
- the long-latency divider CC result.

Pipeline writes are never stalled. TLU writes use a valid/ack handshake. Divider results are buffered in a 2-entry FIFO and dropped if a younger write to the same thread supersedes them. Per-thread pending flags tell the IFU when a thread's CCR is not yet final.

---
 rtl/sparc_exu_ccr_wrsched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sparc_exu_ccr_wrsched.sv
// CCR write-port scheduler: merges pipe, TLU and divider CC writes into one
// registered write port, buffering divider results in a 2-entry FIFO.
module sparc_exu_ccr_wrsched #(
    parameter int AGE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       se,
    input  logic       pipe_wen_w,
    input  logic [1:0] pipe_thr_w,
    input  logic [7:0] pipe_data_w,
    input  logic       tlu_req,
    input  logic [1:0] tlu_thr,
    input  logic [7:0] tlu_data,
    output logic       tlu_ack,
    input  logic       div_vld,
    input  logic [1:0] div_thr,
    input  logic [7:0] div_data,
    output logic       div_rdy,
    output logic       div_drop,
    output logic       ccr_wen,
    output logic [1:0] ccr_wthr,
    output logic [7:0] ccr_wdata,
    output logic [3:0] ccr_pend_thr
);

    // An age limit above the counter's saturation value can never be reached.
    localparam logic [3:0] AGE_LIM = (AGE_MAX > 7) ? 4'd8 : 4'(AGE_MAX);

    logic            unused_se;
    logic [1:0]      vld, stale;
    logic [1:0][1:0] ent_thr;
    logic [1:0][7:0] ent_data;
    logic [2:0]      age;

    logic [1:0]      vld_nxt, stale_nxt;
    logic [1:0][1:0] thr_nxt;
    logic [1:0][7:0] data_nxt;
    logic [2:0]      age_nxt;

    logic head_ok, aged, div_win, head_stale, pop, push;

    assign unused_se = se;

    // Slot 0 is always the head; the FIFO shifts down on pop.
    assign head_ok    = vld[0] & ~stale[0];
    assign head_stale = vld[0] & stale[0];
    assign aged       = head_ok & ({1'b0, age} >= AGE_LIM);

    assign div_win  = ~pipe_wen_w & head_ok & (aged | ~tlu_req);
    assign tlu_ack  = ~reset & tlu_req & ~pipe_wen_w & ~aged;
    assign div_drop = ~reset & head_stale;
    assign div_rdy  = ~(vld[0] & vld[1]) & ~reset;

    assign pop  = div_win | head_stale;
    assign push = div_vld & div_rdy;

    always_comb begin
        vld_nxt   = vld;
        stale_nxt = stale;
        thr_nxt   = ent_thr;
        data_nxt  = ent_data;
        if (pop) begin
            vld_nxt     = {1'b0, vld[1]};
            stale_nxt   = {1'b0, stale[1]};
            thr_nxt[0]  = ent_thr[1];
            data_nxt[0] = ent_data[1];
        end
        if (push) begin
            if (!vld_nxt[0]) begin
                vld_nxt[0]   = 1'b1;
                stale_nxt[0] = 1'b0;
                thr_nxt[0]   = div_thr;
                data_nxt[0]  = div_data;
            end else begin
                vld_nxt[1]   = 1'b1;
                stale_nxt[1] = 1'b0;
                thr_nxt[1]   = div_thr;
                data_nxt[1]  = div_data;
            end
        end
        // Any younger write to the same thread supersedes buffered divider results.
        for (int i = 0; i < 2; i++) begin
            if (vld_nxt[i] && ((pipe_wen_w && thr_nxt[i] == pipe_thr_w) ||
                               (tlu_ack && thr_nxt[i] == tlu_thr)))
                stale_nxt[i] = 1'b1;
        end
    end

    always_comb begin
        age_nxt = age;
        if (pop || !vld[0])
            age_nxt = 3'd0;
        else if (head_ok && age != 3'd7)
            age_nxt = age + 3'd1;
    end

    always_comb begin
        ccr_pend_thr = 4'd0;
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && !stale[i])
                ccr_pend_thr[ent_thr[i]] = 1'b1;
        end
        if (reset)
            ccr_pend_thr = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= 2'b00;
            stale <= 2'b00;
            age   <= 3'd0;
        end else begin
            vld   <= vld_nxt;
            stale <= stale_nxt;
            age   <= age_nxt;
        end
    end

    // Entry payload is qualified by vld, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_thr  <= thr_nxt;
        ent_data <= data_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ccr_wen   <= 1'b0;
            ccr_wthr  <= 2'd0;
            ccr_wdata <= 8'd0;
        end else begin
            ccr_wen <= pipe_wen_w | div_win | tlu_ack;
            if (pipe_wen_w) begin
                ccr_wthr  <= pipe_thr_w;
                ccr_wdata <= pipe_data_w;
            end else if (div_win) begin
                ccr_wthr  <= ent_thr[0];
                ccr_wdata <= ent_data[0];
            end else if (tlu_ack) begin
                ccr_wthr  <= tlu_thr;
                ccr_wdata <= tlu_data;
            end
        end
    end

endmodule
